cache_req_queue: RTL and testbench
==================================

CACHE_REQ_QUEUE -- requirements
Module: cache_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4; request entries held (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 48; cache address width.
REQ-003 SHALL have parameter CNT_W, default 12; statistics counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-low.
REQ-006 in_valid  input  1  trace source offers a request.
REQ-007 in_op  input  1  0 = read, 1 = write.
REQ-008 in_addr  input  ADDR_W  request byte address.
REQ-009 in_ready  output  1  queue accepts a request this cycle.
REQ-010 req_valid  output  1  head request presented to cache_top.
REQ-011 req_op  output  1  head request operation.
REQ-012 req_addr  output  ADDR_W  head request address (drives cache_addr).
REQ-013 req_ready  input  1  cache_top consumes head this cycle.
REQ-014 occupancy  output  $clog2(DEPTH)+1  entries held.
REQ-015 num_reads  output  CNT_W  reads handed to cache.
REQ-016 num_writes  output  CNT_W  writes handed to cache.

Function
REQ-017 Push SHALL occur iff in_valid && in_ready; pop SHALL occur iff req_valid && req_ready.
REQ-018 in_ready SHALL equal (occupancy < DEPTH), registered state only; no combinational path from req_ready.
REQ-019 req_valid SHALL equal (occupancy != 0); req_op/req_addr SHALL be the oldest entry (FIFO order, first-word-fall-through from storage).
REQ-020 Push-to-req_valid latency SHALL be 1 cycle; no same-cycle bypass when empty.
REQ-021 req_op/req_addr SHALL remain stable while req_valid && !req_ready.
REQ-022 When req_valid is 0, req_op and req_addr SHALL be 0.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; allowed at any non-empty, non-full level.
REQ-024 Full: in_ready 0, in_valid ignored, storage unchanged; push while full SHALL NOT overwrite.
REQ-025 Full with pop: in_ready rises the next cycle (not the same cycle).
REQ-026 Empty: req_ready ignored; occupancy never underflows.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH.
REQ-028 Each pop SHALL increment num_reads (op 0) or num_writes (op 1) by 1, visible the cycle after the pop.
REQ-029 Counters SHALL saturate at 2^CNT_W-1 and not wrap.

Reset
REQ-030 While reset is 0 at a clock edge: occupancy 0, pointers 0, num_reads 0, num_writes 0, req_valid 0, req_op 0, req_addr 0, in_ready 1 after the edge.
REQ-031 Reset mid-operation SHALL discard all held entries; a push or pop coincident with a reset edge SHALL have no effect.
REQ-032 Storage array contents need not be reset; outputs SHALL NOT expose them while empty.

Structure
REQ-033 Package cache_pkg SHALL hold ADDR_W default, CNT_W default, op encoding constants (OP_READ=0, OP_WRITE=1) and the request record {op, addr}.
REQ-034 One sub-module sat_counter (CNT_W, increment enable, sync active-low reset) SHALL implement both statistics counters.
REQ-035 No other sub-modules; storage SHALL be a register array.

Verification
REQ-036 Reset low 1 cycle, then push read 48'h7fff493822b0 with req_ready=1 -> req_valid next cycle with that address, num_reads=1 cycle after pop, occupancy back to 0.
REQ-037 req_ready=0, push 5 requests (DEPTH=4) -> in_ready 0 after 4th, 5th not stored; release req_ready -> 4 addresses out in push order.
REQ-038 Occupancy 2, simultaneous push write 48'h7f3035f6a7c0 and pop -> occupancy stays 2; write appears after older entry; num_writes increments only when it pops.
REQ-039 Hold req_ready=0 for 3 cycles with head 48'h7fff493822a8 -> req_addr/req_op unchanged each cycle.
REQ-040 Force 4095 reads through -> num_reads=12'hFFF; one more read -> stays 12'hFFF.
REQ-041 Occupancy 3, assert reset with in_valid and req_ready high -> occupancy 0, counters 0, req_valid 0 next cycle.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache request path: default widths, op encoding
// and the {op, addr} request record.
package cache_pkg;

  localparam int unsigned ADDR_W_DEF = 48;
  localparam int unsigned CNT_W_DEF  = 12;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [ADDR_W_DEF-1:0] addr;
  } req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_req_queue.sv
// FIFO of cache requests between the trace source and cache_top, with
// saturating counts of reads and writes handed to the cache.
module cache_req_queue
  import cache_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_op,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     in_ready,
  output logic                     req_valid,
  output logic                     req_op,
  output logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         num_reads,
  output logic [CNT_W-1:0]         num_writes
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  op_e               op_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              push;
  logic              pop;
  logic              inc_reads;
  logic              inc_writes;

  // Handshakes depend only on registered occupancy, never on req_ready.
  always_comb begin
    in_ready   = (occ < OCC_W'(DEPTH));
    req_valid  = (occ != '0);
    push       = in_valid && in_ready;
    pop        = req_valid && req_ready;
    req_op     = req_valid ? op_mem[rd_ptr] : 1'b0;
    req_addr   = req_valid ? addr_mem[rd_ptr] : '0;
    inc_reads  = pop && (op_mem[rd_ptr] == OP_READ);
    inc_writes = pop && (op_mem[rd_ptr] == OP_WRITE);
    occupancy  = occ;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset; the read mux masks it whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      op_mem[wr_ptr]   <= op_e'(in_op);
      addr_mem[wr_ptr] <= in_addr;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_reads (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_reads),
    .count (num_reads)
  );

  sat_counter #(.CNT_W(CNT_W)) u_writes (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_writes),
    .count (num_writes)
  );

endmodule

// File: tb/tb_cache_req_queue.sv
// Directed bench for cache_req_queue: stimulus pushes expected requests into a
// scoreboard, a negedge monitor checks every pop and the statistics counters.
module tb_cache_req_queue;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_op;
  logic [47:0] in_addr;
  logic        in_ready;
  logic        req_valid;
  logic        req_op;
  logic [47:0] req_addr;
  logic        req_ready;
  logic [2:0]  occupancy;
  logic [11:0] num_reads;
  logic [11:0] num_writes;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_reads  = 0;
  int unsigned exp_writes = 0;
  req_t        sb [$];

  always #5 clk = ~clk;

  cache_req_queue #(.DEPTH(4), .ADDR_W(48), .CNT_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_addr    (in_addr),
    .in_ready   (in_ready),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .occupancy  (occupancy),
    .num_reads  (num_reads),
    .num_writes (num_writes)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op, input logic [47:0] addr, input bit accept);
    req_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    if (accept) begin
      e.op   = op_e'(op);
      e.addr = addr;
      sb.push_back(e);
    end
  endtask

  // Monitor: counters compared every cycle, popped head compared to scoreboard.
  always @(negedge clk) begin
    check("num_reads",  64'(num_reads),  64'(exp_reads));
    check("num_writes", 64'(num_writes), 64'(exp_writes));
    if (!req_valid) begin
      check("idle_op",   64'(req_op),   64'd0);
      check("idle_addr", 64'(req_addr), 64'd0);
    end
    if (!reset) begin
      sb.delete();
      exp_reads  = 0;
      exp_writes = 0;
    end else if (req_valid && req_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got pop with addr %0h expected no pop", req_addr);
      end else begin
        req_t e;
        e = sb.pop_front();
        check("pop_op",   64'(req_op),   64'(e.op));
        check("pop_addr", 64'(req_addr), 64'(e.addr));
        if (e.op == OP_READ) begin
          if (exp_reads < 4095) exp_reads++;
        end else begin
          if (exp_writes < 4095) exp_writes++;
        end
      end
    end
  end

  initial begin
    logic [47:0] b_addr [5];
    b_addr[0] = 48'h1000_0000_0010;
    b_addr[1] = 48'h1000_0000_0020;
    b_addr[2] = 48'h1000_0000_0030;
    b_addr[3] = 48'h1000_0000_0040;
    b_addr[4] = 48'h1000_0000_0050;

    reset = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_addr = '0; req_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_occ",       64'(occupancy),  64'd0);
    check("rst_in_ready",  64'(in_ready),   64'd1);
    check("rst_req_valid", 64'(req_valid),  64'd0);
    check("rst_req_addr",  64'(req_addr),   64'd0);
    check("rst_reads",     64'(num_reads),  64'd0);
    reset = 1'b1;

    // Single read through an empty queue.
    req_ready = 1'b1;
    drive(1'b0, 48'h7fff493822b0, 1'b1);
    #1 check("no_bypass", 64'(req_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("t1_occ1",  64'(occupancy), 64'd1);
    check("t1_addr",  64'(req_addr),  64'h7fff493822b0);
    tick();
    check("t1_occ0",  64'(occupancy), 64'd0);
    check("t1_reads", 64'(num_reads), 64'd1);

    // Fill to full with the consumer stalled; fifth offer is dropped.
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'(i), b_addr[i], 1'b1);
      tick();
    end
    check("full_in_ready", 64'(in_ready),  64'd0);
    check("full_occ",      64'(occupancy), 64'd4);
    drive(1'b0, b_addr[4], 1'b0);
    tick();
    check("full_no_overwrite", 64'(occupancy), 64'd4);
    req_ready = 1'b1;
    #1 check("full_pop_ready_same", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    check("full_pop_ready_next", 64'(in_ready),  64'd1);
    check("full_pop_occ",        64'(occupancy), 64'd3);
    for (int i = 0; i < 3; i++) tick();
    check("drain_occ", 64'(occupancy), 64'd0);
    tick(); tick();
    check("empty_pop_occ", 64'(occupancy), 64'd0);

    // Simultaneous push and pop at occupancy 2.
    req_ready = 1'b0;
    drive(1'b0, 48'h2000_0000_0100, 1'b1); tick();
    drive(1'b0, 48'h2000_0000_0200, 1'b1); tick();
    check("pp_occ_before", 64'(occupancy), 64'd2);
    drive(1'b1, 48'h7f3035f6a7c0, 1'b1);
    req_ready = 1'b1;
    tick();
    in_valid = 1'b0; req_ready = 1'b0;
    check("pp_occ_after",  64'(occupancy),  64'd2);
    check("pp_writes",     64'(num_writes), 64'd2);
    req_ready = 1'b1;
    tick(); tick();
    check("pp_drain_occ",  64'(occupancy),  64'd0);
    check("pp_writes_end", 64'(num_writes), 64'd3);

    // Head held stable under backpressure.
    req_ready = 1'b0;
    drive(1'b0, 48'h7fff493822a8, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 64'(req_valid), 64'd1);
      check("hold_addr",  64'(req_addr),  64'h7fff493822a8);
      check("hold_op",    64'(req_op),    64'd0);
      tick();
    end
    req_ready = 1'b1;
    tick();

    // Saturation: clear counters, then stream 4095 reads plus one more.
    reset = 1'b0; tick(); reset = 1'b1;
    check("sat_start", 64'(num_reads), 64'd0);
    for (int i = 0; i < 4095; i++) begin
      drive(1'b0, 48'h3000_0000_0000 + 48'(i), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("sat_fff", 64'(num_reads), 64'hfff);
    drive(1'b0, 48'h3fff_0000_0000, 1'b1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("sat_hold", 64'(num_reads), 64'hfff);

    // Reset with three entries held and both handshakes asserted.
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 48'h4000_0000_0000 + 48'(i), 1'b1);
      tick();
    end
    check("mid_occ3", 64'(occupancy), 64'd3);
    reset = 1'b0;
    drive(1'b0, 48'h4fff_0000_0000, 1'b0);
    req_ready = 1'b1;
    tick();
    check("mid_rst_occ",    64'(occupancy),  64'd0);
    check("mid_rst_valid",  64'(req_valid),  64'd0);
    check("mid_rst_reads",  64'(num_reads),  64'd0);
    check("mid_rst_writes", 64'(num_writes), 64'd0);
    check("mid_rst_ready",  64'(in_ready),   64'd1);
    reset = 1'b1; in_valid = 1'b0;
    tick(); tick();
    check("post_rst_occ", 64'(occupancy), 64'd0);
    check("sb_empty",     64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
